calc1_port_sched: RTL and testbench
===================================

# calc1_port_sched

Four-port front end for a single shared calc1 ALU. It captures each port's two-cycle command/operand sequence, schedules pending operations onto one ALU with round-robin arbitration, and returns a one-cycle response to the originating port. It sits between the per-port stimulus/requester interfaces and the arithmetic datapath, and replaces per-port ALU duplication.

## Interface
- NPORTS, 4, number of requester ports, indexed 1..NPORTS.
- DW, 32, operand/result width.
- c_clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  reset is asynchronous and active-low.
- req_cmd_in[1:NPORTS]  in  4 each  command; sampled only while that port is idle.
- req_data_in[1:NPORTS]  in  DW each  operand 1 in the command cycle, operand 2 in the following cycle.
- req_busy[1:NPORTS]  out  1 each  port holds an unfinished command; new commands are ignored.
- out_resp[1:NPORTS]  out  2 each  00 none, 01 success, 10 overflow/underflow/invalid; 11 never driven.
- out_data[1:NPORTS]  out  DW each  result; 0 unless out_resp is 01.

## Operation
- Commands: 0 NOP, 1 ADD, 2 SUB, 5 LSH, 6 RSH. All other codes are invalid.
- Per-port FSM: IDLE -> OP2 -> PEND -> IDLE.
  - IDLE: on a nonzero command, latch the command and operand 1, then go to OP2.
  - OP2: latch operand 2 unconditionally and go to PEND. The command input is ignored in this state.
  - PEND: wait for a grant. On a grant, go to IDLE at the edge that registers the response.
- Invalid commands follow the full sequence: both operand cycles, arbitration, then response 10 with data 0. This preserves response ordering and timing.
- req_busy is 1 exactly when the port is in OP2 or PEND.
- Arbiter:
  - At most one grant per cycle, given to a port in PEND.
  - Round-robin: the search starts at last_grant+1 and wraps from NPORTS to 1.
  - last_grant resets to NPORTS, so port 1 has first priority.
  - last_grant updates only on a grant.
- ALU rules (unsigned):
  - ADD: if there is a carry-out, respond 10 with data 0; otherwise respond 01 with op1+op2.
  - SUB: if op2 > op1, respond 10 with data 0; otherwise respond 01 with op1-op2.
  - LSH and RSH: op1 shifted logically by op2[4:0]; op2[DW-1:5] is ignored; the response is always 01.
- Responses:
  - out_resp and out_data are registered.
  - A non-zero value lasts exactly one cycle, then returns to 00/0.
  - Only the granted port's outputs change.

## Timing
- Reset (asserted asynchronously, released synchronously to c_clk by the environment):
  - All FSMs go to IDLE.
  - req_busy = 0, out_resp = 00, out_data = 0, last_grant = NPORTS.
  - All latched operands are cleared.
  - Reset mid-operation discards every pending command and produces no response for it.
- Uncontended latency:
  - Command sampled at edge E0, operand 2 at E1.
  - Grant is combinational during the cycle after E1; the response is registered at E2.
  - Response is therefore visible in the cycle after E2, two edges after the command sample.
- Contention: with all four ports commanding at the same E0, responses register at E2, E3, E4, E5 in order 1, 2, 3, 4 (starting from reset pointer).
- Back-to-back on one port:
  - req_busy falls at the response edge.
  - A command presented during the response cycle is accepted at the next edge.
  - Peak per-port rate is one command per 3 cycles.
- Simultaneous events:
  - A port may receive a response and have its next command sampled at consecutive edges, with no idle gap.
  - A command on a busy port is silently dropped, and no response is generated for it.

## Structure
- Shared package calc1_pkg holds:
  - the command localparams CMD_NOP/ADD/SUB/LSH/RSH;
  - the response codes RESP_NONE/OK/ERR;
  - the port FSM state encoding;
  - the default NPORTS and DW.
- Sub-module calc1_rr_arb: the NPORTS-wide round-robin arbiter. Inputs are the pending vector and last_grant; outputs are a one-hot grant and the granted index; it is purely combinational plus the last_grant register.
- The ALU function is inline combinational logic in calc1_port_sched; there is no separate module.

## Test plan
- Port 1, ADD, 0xFFFF0000 then 0x0000FFFF: out_resp[1]=01, out_data[1]=0xFFFFFFFF, two edges after the command; req_busy[1] is high for exactly 2 cycles.
- Port 2:
  - ADD 0xFFFFFFFF + 0x00000001 gives 10/0.
  - SUB 0x00000005 - 0x00000006 gives 10/0.
  - SUB 0x99999999 - 0x55555555 gives 01/0x44444444.
- Port 3:
  - LSH 0x00000001 by 0x00000021 gives 01/0x00000002.
  - RSH 0x80000000 by 0x0000001F gives 01/0x00000001.
  - Invalid command 3 gives 10/0 at normal latency.
- All ports issue ADD 0x55555555+0x99999999 at the same edge: each gets 01/0xEEEEEEEE, on consecutive cycles in port order 1, 2, 3, 4.
  - A second round from all ports is served in order 1, 2, 3, 4 again.
  - Then port 3 alone re-requests while ports 1 and 4 are pending: order is 4, 1, 3 if last_grant=3.
- Port 4 issues a command while busy: the command is dropped, exactly one response appears, and a command presented in the response cycle is accepted.
- Assert reset_n low while ports 1 to 3 are in OP2 or PEND: all outputs go to 0 immediately, there are no responses after release, and the first post-reset grant goes to port 1.

Source files
------------

// File: rtl/calc1_pkg.sv
// Shared definitions for the calc1 four-port scheduler: command and response
// codes, the per-port FSM encoding and default sizing.
package calc1_pkg;

  localparam int CALC1_NPORTS = 4;
  localparam int CALC1_DW     = 32;
  localparam int SHAMT_W      = 5;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_LSH = 4'd5;
  localparam logic [3:0] CMD_RSH = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'b00;
  localparam logic [1:0] RESP_OK   = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP2  = 2'd1,
    ST_PEND = 2'd2
  } port_state_t;

endpackage

// File: rtl/calc1_rr_arb.sv
// Round-robin arbiter over ports 1..NPORTS: the search starts one past the
// last granted port and wraps; the pointer only moves when a grant is issued.
module calc1_rr_arb #(
  parameter int NPORTS = 4,
  parameter int IW     = $clog2(NPORTS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NPORTS:1]   pending,
  output logic [NPORTS:1]   grant,
  output logic [IW-1:0]     grant_idx
);

  localparam int IW1 = IW + 1;

  logic [IW-1:0] last_grant_reg;
  logic [IW:0]   cand_sum;
  logic [IW-1:0] cand;

  // grant_idx of zero means "nothing granted yet"; valid port indices start at 1
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int off = 1; off <= NPORTS; off++) begin
      cand_sum = {1'b0, last_grant_reg} + IW1'(off);
      if (cand_sum > IW1'(NPORTS)) begin
        cand_sum = cand_sum - IW1'(NPORTS);
      end
      cand = cand_sum[IW-1:0];
      if ((grant_idx == '0) && pending[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= IW'(NPORTS);
    end else if (grant_idx != '0) begin
      last_grant_reg <= grant_idx;
    end
  end

endmodule

// File: rtl/calc1_port_sched.sv
// Four-port front end sharing one calc1 ALU: per-port capture FSMs, a
// round-robin grant and a one-cycle registered response to the granted port.
module calc1_port_sched
  import calc1_pkg::*;
#(
  parameter int NPORTS = CALC1_NPORTS,
  parameter int DW     = CALC1_DW
) (
  input  logic          c_clk,
  input  logic          reset_n,
  input  logic [3:0]    req_cmd_in  [1:NPORTS],
  input  logic [DW-1:0] req_data_in [1:NPORTS],
  output logic          req_busy    [1:NPORTS],
  output logic [1:0]    out_resp    [1:NPORTS],
  output logic [DW-1:0] out_data    [1:NPORTS]
);

  localparam int IW = $clog2(NPORTS + 1);

  logic [NPORTS:1] pending;
  logic [NPORTS:1] grant;
  logic [IW-1:0]   grant_idx;
  logic            grant_valid;

  logic [3:0]      cmd_arr [1:NPORTS];
  logic [DW-1:0]   op1_arr [1:NPORTS];
  logic [DW-1:0]   op2_arr [1:NPORTS];

  logic [3:0]      sel_cmd;
  logic [DW-1:0]   sel_op1;
  logic [DW-1:0]   sel_op2;
  logic [DW:0]     add_sum;
  logic [1:0]      alu_resp;
  logic [DW-1:0]   alu_data;

  calc1_rr_arb #(
    .NPORTS (NPORTS),
    .IW     (IW)
  ) u_arb (
    .clk       (c_clk),
    .rst_n     (reset_n),
    .pending   (pending),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign grant_valid = |grant;
  assign sel_cmd     = grant_valid ? cmd_arr[grant_idx] : CMD_NOP;
  assign sel_op1     = grant_valid ? op1_arr[grant_idx] : '0;
  assign sel_op2     = grant_valid ? op2_arr[grant_idx] : '0;
  assign add_sum     = {1'b0, sel_op1} + {1'b0, sel_op2};

  // Shared ALU; anything not explicitly successful, including unknown codes, is an error
  always_comb begin
    alu_resp = RESP_ERR;
    alu_data = '0;
    case (sel_cmd)
      CMD_ADD: begin
        if (!add_sum[DW]) begin
          alu_resp = RESP_OK;
          alu_data = add_sum[DW-1:0];
        end
      end
      CMD_SUB: begin
        if (sel_op2 <= sel_op1) begin
          alu_resp = RESP_OK;
          alu_data = sel_op1 - sel_op2;
        end
      end
      CMD_LSH: begin
        alu_resp = RESP_OK;
        alu_data = sel_op1 << sel_op2[SHAMT_W-1:0];
      end
      CMD_RSH: begin
        alu_resp = RESP_OK;
        alu_data = sel_op1 >> sel_op2[SHAMT_W-1:0];
      end
      default: begin
        alu_resp = RESP_ERR;
        alu_data = '0;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 1; gi <= NPORTS; gi++) begin : g_port
      port_state_t   state_reg;
      port_state_t   state_next;
      logic [3:0]    cmd_reg;
      logic [DW-1:0] op1_reg;
      logic [DW-1:0] op2_reg;
      logic [1:0]    resp_reg;
      logic [DW-1:0] data_reg;

      always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
          state_reg <= ST_IDLE;
        end else begin
          state_reg <= state_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        case (state_reg)
          ST_IDLE: if (req_cmd_in[gi] != CMD_NOP) state_next = ST_OP2;
          ST_OP2:  state_next = ST_PEND;
          ST_PEND: if (grant[gi]) state_next = ST_IDLE;
          default: state_next = ST_IDLE;
        endcase
      end

      always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
          cmd_reg <= CMD_NOP;
          op1_reg <= '0;
          op2_reg <= '0;
        end else begin
          if ((state_reg == ST_IDLE) && (req_cmd_in[gi] != CMD_NOP)) begin
            cmd_reg <= req_cmd_in[gi];
            op1_reg <= req_data_in[gi];
          end
          if (state_reg == ST_OP2) begin
            op2_reg <= req_data_in[gi];
          end
        end
      end

      // Response is a single-cycle pulse; every non-granted cycle drives 00/0
      always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
          resp_reg <= RESP_NONE;
          data_reg <= '0;
        end else if (grant[gi]) begin
          resp_reg <= alu_resp;
          data_reg <= alu_data;
        end else begin
          resp_reg <= RESP_NONE;
          data_reg <= '0;
        end
      end

      assign pending[gi]  = (state_reg == ST_PEND);
      assign req_busy[gi] = (state_reg == ST_OP2) || (state_reg == ST_PEND);
      assign out_resp[gi] = resp_reg;
      assign out_data[gi] = data_reg;
      assign cmd_arr[gi]  = cmd_reg;
      assign op1_arr[gi]  = op1_reg;
      assign op2_arr[gi]  = op2_reg;
    end
  endgenerate

endmodule

// File: tb/tb_calc1_port_sched.sv
// Directed-vector bench for calc1_port_sched with hand-computed expectations.
module tb_calc1_port_sched;
  import calc1_pkg::*;

  localparam int NP = 4;
  localparam int DW = 32;

  logic          c_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [3:0]    cmd_in  [1:NP];
  logic [DW-1:0] data_in [1:NP];
  logic          busy    [1:NP];
  logic [1:0]    resp    [1:NP];
  logic [DW-1:0] rdata   [1:NP];

  int n_vec = 0;
  int n_bad = 0;

  always #5 c_clk = ~c_clk;

  calc1_port_sched #(.NPORTS(NP), .DW(DW)) dut (
    .c_clk       (c_clk),
    .reset_n     (reset_n),
    .req_cmd_in  (cmd_in),
    .req_data_in (data_in),
    .req_busy    (busy),
    .out_resp    (resp),
    .out_data    (rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  function automatic logic [7:0] resp_vec();
    logic [7:0] v;
    v = '0;
    for (int p = 1; p <= NP; p++) v[2*(p-1) +: 2] = resp[p];
    return v;
  endfunction

  function automatic logic [3:0] busy_vec();
    logic [3:0] v;
    v = '0;
    for (int p = 1; p <= NP; p++) v[p-1] = busy[p];
    return v;
  endfunction

  function automatic logic [DW-1:0] data_or();
    logic [DW-1:0] v;
    v = '0;
    for (int p = 1; p <= NP; p++) v = v | rdata[p];
    return v;
  endfunction

  task automatic clear_inputs();
    for (int p = 1; p <= NP; p++) begin
      cmd_in[p]  = CMD_NOP;
      data_in[p] = '0;
    end
  endtask

  // Two-cycle command sequence on every port in mask; returns at E1+1
  task automatic issue(input logic [3:0] mask, input logic [3:0] cmd,
                       input logic [DW-1:0] a, input logic [DW-1:0] b);
    for (int p = 1; p <= NP; p++) if (mask[p-1]) begin
      cmd_in[p]  = cmd;
      data_in[p] = a;
    end
    tick();
    for (int p = 1; p <= NP; p++) if (mask[p-1]) begin
      cmd_in[p]  = CMD_NOP;
      data_in[p] = b;
    end
    tick();
    for (int p = 1; p <= NP; p++) if (mask[p-1]) data_in[p] = '0;
  endtask

  // Exactly one port responding this cycle, with the given code and data
  task automatic expect_one(input string tag, input int port,
                            input logic [1:0] r, input logic [DW-1:0] d);
    logic [7:0] e;
    e = '0;
    e[2*(port-1) +: 2] = r;
    check({tag, " resp"}, resp_vec(), e);
    check({tag, " data"}, rdata[port], d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge c_clk);
    #1;
    check("reset busy", busy_vec(), 4'b0000);
    check("reset resp", resp_vec(), 8'h00);
    check("reset data", data_or(), 32'h0);
    reset_n = 1'b1;
    tick();

    // Port 1 ADD with exact latency and busy width
    cmd_in[1]  = CMD_ADD;
    data_in[1] = 32'hFFFF0000;
    tick();
    check("p1 busy E0", busy_vec(), 4'b0001);
    cmd_in[1]  = CMD_NOP;
    data_in[1] = 32'h0000FFFF;
    tick();
    data_in[1] = '0;
    check("p1 busy E1", busy_vec(), 4'b0001);
    check("p1 no early resp", resp_vec(), 8'h00);
    tick();
    expect_one("p1 add", 1, RESP_OK, 32'hFFFFFFFF);
    check("p1 busy after resp", busy_vec(), 4'b0000);
    tick();
    check("p1 resp one cycle", resp_vec(), 8'h00);

    // Port 2 overflow/underflow/normal subtract
    issue(4'b0010, CMD_ADD, 32'hFFFFFFFF, 32'h00000001);
    tick();
    expect_one("p2 add ovf", 2, RESP_ERR, 32'h0);
    issue(4'b0010, CMD_SUB, 32'h00000005, 32'h00000006);
    tick();
    expect_one("p2 sub udf", 2, RESP_ERR, 32'h0);
    issue(4'b0010, CMD_SUB, 32'h99999999, 32'h55555555);
    tick();
    expect_one("p2 sub", 2, RESP_OK, 32'h44444444);

    // Port 3 shifts (upper shift bits ignored) and an invalid code
    issue(4'b0100, CMD_LSH, 32'h00000001, 32'h00000021);
    tick();
    expect_one("p3 lsh", 3, RESP_OK, 32'h00000002);
    issue(4'b0100, CMD_RSH, 32'h80000000, 32'h0000001F);
    tick();
    expect_one("p3 rsh", 3, RESP_OK, 32'h00000001);
    issue(4'b0100, 4'd3, 32'h12345678, 32'h00000001);
    tick();
    expect_one("p3 invalid", 3, RESP_ERR, 32'h0);

    // Port 4: command while busy is dropped; command in response cycle accepted
    cmd_in[4]  = CMD_ADD;
    data_in[4] = 32'd1;
    tick();
    cmd_in[4]  = CMD_NOP;
    data_in[4] = 32'd2;
    tick();
    cmd_in[4]  = CMD_SUB;
    data_in[4] = 32'h100;
    tick();
    expect_one("p4 first", 4, RESP_OK, 32'd3);
    check("p4 busy at resp", busy_vec(), 4'b0000);
    cmd_in[4]  = CMD_SUB;
    data_in[4] = 32'd10;
    tick();
    check("p4 accepted", busy_vec(), 4'b1000);
    cmd_in[4]  = CMD_NOP;
    data_in[4] = 32'd3;
    tick();
    data_in[4] = '0;
    check("p4 no dropped resp", resp_vec(), 8'h00);
    tick();
    expect_one("p4 second", 4, RESP_OK, 32'd7);
    tick();
    check("p4 no extra resp", resp_vec(), 8'h00);

    // Contention, two rounds, pointer at port 4
    for (int round = 0; round < 2; round++) begin
      issue(4'b1111, CMD_ADD, 32'h55555555, 32'h99999999);
      for (int p = 1; p <= NP; p++) begin
        tick();
        expect_one($sformatf("rr round%0d p%0d", round, p), p, RESP_OK, 32'hEEEEEEEE);
      end
    end

    // Pointer to port 3, then ports 1,3,4 together -> order 4,1,3
    issue(4'b0100, CMD_ADD, 32'd5, 32'd6);
    tick();
    expect_one("p3 solo", 3, RESP_OK, 32'd11);
    issue(4'b1101, CMD_ADD, 32'd20, 32'd22);
    tick();
    expect_one("order 4", 4, RESP_OK, 32'd42);
    tick();
    expect_one("order 1", 1, RESP_OK, 32'd42);
    tick();
    expect_one("order 3", 3, RESP_OK, 32'd42);

    // Mid-operation reset with pointer at port 3
    for (int p = 1; p <= 3; p++) begin
      cmd_in[p]  = CMD_ADD;
      data_in[p] = 32'd1;
    end
    tick();
    clear_inputs();
    check("pre-reset busy", busy_vec(), 4'b0111);
    #3;
    reset_n = 1'b0;
    #1;
    check("async reset busy", busy_vec(), 4'b0000);
    check("async reset resp", resp_vec(), 8'h00);
    repeat (2) @(posedge c_clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("post-reset quiet %0d", i), {busy_vec(), resp_vec()}, 12'h000);
    end
    issue(4'b1111, CMD_SUB, 32'd9, 32'd4);
    for (int p = 1; p <= NP; p++) begin
      tick();
      expect_one($sformatf("post-reset p%0d", p), p, RESP_OK, 32'd5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
